mic_spi_capture: RTL and testbench



---
 rtl/mic_spi_capture.sv | 130 +++++++++++++
 tb/tb_mic_spi_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_spi_capture.sv
// SPI capture engine for an ADCS7476-style ADC. It divides the system clock into a sample tick and sCLK
// and returns each 12-bit conversion with a one-cycle DataReady strobe.
module mic_spi_capture #(
    parameter int unsigned CLK_DIV    = 20,
    parameter int unsigned SAMPLE_DIV = 10000,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 MISO,
    output logic                 nSS,
    output logic                 sCLK,
    output logic [DATA_BITS-1:0] SoundData,
    output logic                 DataReady,
    output logic                 FrameError,
    output logic                 Overrun
);

    localparam int unsigned SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned HW = $clog2(CLK_DIV + 1);
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_QUIET = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [SW-1:0]         samp_cnt;
    logic [HW-1:0]         half_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  tick_c;
    logic                  half_last_c;
    logic                  rise_c;

    // Sample-rate divider; held at zero while disabled so no tick can occur.
    always_ff @(posedge Clock) begin
        if (Reset || !Enable) begin
            samp_cnt <= '0;
        end else if (samp_cnt == SW'(SAMPLE_DIV - 1)) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= samp_cnt + SW'(1);
        end
    end

    always_comb begin
        tick_c      = Enable && (samp_cnt == SW'(SAMPLE_DIV - 1));
        half_last_c = (half_cnt == HW'(CLK_DIV - 1));
        rise_c      = (state == ST_SHIFT) && half_last_c && !sCLK;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (tick_c) state_next = ST_SHIFT;
            ST_SHIFT: if (rise_c && bit_cnt == BW'(FRAME_BITS - 1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_QUIET;
            ST_QUIET: if (half_last_c) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Serial clock, chip select, shift register and result registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            nSS        <= 1'b1;
            sCLK       <= 1'b1;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            SoundData  <= '0;
            DataReady  <= 1'b0;
            FrameError <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            DataReady <= 1'b0;
            if (tick_c && state != ST_IDLE) begin
                Overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    sCLK     <= 1'b1;
                    nSS      <= !tick_c;
                end
                ST_SHIFT: begin
                    if (half_last_c) begin
                        half_cnt <= '0;
                        sCLK     <= !sCLK;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                    if (rise_c) begin
                        shreg   <= {shreg[FRAME_BITS-2:0], MISO};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                ST_DONE: begin
                    nSS        <= 1'b1;
                    sCLK       <= 1'b1;
                    half_cnt   <= '0;
                    SoundData  <= shreg[DATA_BITS-1:0];
                    FrameError <= |shreg[FRAME_BITS-1:DATA_BITS];
                    DataReady  <= 1'b1;
                end
                default: begin
                    // Quiet time: bus idle for one sCLK half-period before the next frame.
                    nSS      <= 1'b1;
                    sCLK     <= 1'b1;
                    half_cnt <= half_last_c ? '0 : half_cnt + HW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_spi_capture.sv
// Bench for mic_spi_capture: three instances (default, fast legal, illegal sample rate) with
// ADC models and a DataReady scoreboard.
`timescale 1ns/1ps
module tb_mic_spi_capture;

    localparam int CLK_DIV    = 20;
    localparam int FRAME_BITS = 16;
    localparam int DIV_A      = 10000;
    localparam int DIV_B      = 700;
    localparam int DIV_C      = 500;
    localparam int LAT        = 642;

    typedef struct {
        int         dut;
        int         t;
        logic [11:0] data;
        logic       fe;
    } exp_t;

    typedef struct {
        int          dut;
        logic [15:0] w;
    } adc_t;

    logic        clk = 1'b0;
    logic        rst  [3] = '{1'b1, 1'b1, 1'b1};
    logic        en   [3] = '{1'b0, 1'b0, 1'b0};
    logic        miso [3] = '{1'b0, 1'b0, 1'b0};
    logic        nss  [3];
    logic        sclk [3];
    logic        dr   [3];
    logic        fe   [3];
    logic        ovr  [3];
    logic [11:0] sd   [3];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          rel = 0;
    bit          mon_on = 1'b0;
    exp_t        sbq[$];
    adc_t        adcq[$];
    exp_t        mon_e;
    adc_t        adc_e;

    logic        rst_seen  [2] = '{1'b1, 1'b1};
    logic        prev_nss  [2] = '{1'b1, 1'b1};
    logic        prev_sclk [2] = '{1'b1, 1'b1};
    bit          in_frame  [2] = '{1'b0, 1'b0};
    int          last_edge [2] = '{0, 0};
    int          rises     [2] = '{0, 0};
    int          low_cnt   [2] = '{0, 0};
    int          falls     [2] = '{0, 0};
    logic [11:0] exp_sd    [2] = '{12'h0, 12'h0};
    logic        exp_fe    [2] = '{1'b0, 1'b0};
    logic [15:0] adc_w     [2] = '{16'h0, 16'h0};
    int          adc_idx   [2] = '{0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) rst_seen[i] <= rst[i];
    end

    mic_spi_capture dut_a (
        .Clock(clk), .Reset(rst[0]), .Enable(en[0]), .MISO(miso[0]),
        .nSS(nss[0]), .sCLK(sclk[0]), .SoundData(sd[0]),
        .DataReady(dr[0]), .FrameError(fe[0]), .Overrun(ovr[0])
    );

    mic_spi_capture #(.SAMPLE_DIV(DIV_B)) dut_b (
        .Clock(clk), .Reset(rst[1]), .Enable(en[1]), .MISO(miso[1]),
        .nSS(nss[1]), .sCLK(sclk[1]), .SoundData(sd[1]),
        .DataReady(dr[1]), .FrameError(fe[1]), .Overrun(ovr[1])
    );

    mic_spi_capture #(.SAMPLE_DIV(DIV_C)) dut_c (
        .Clock(clk), .Reset(rst[2]), .Enable(en[2]), .MISO(miso[2]),
        .nSS(nss[2]), .sCLK(sclk[2]), .SoundData(sd[2]),
        .DataReady(dr[2]), .FrameError(fe[2]), .Overrun(ovr[2])
    );

    // ADC model (shifts on sCLK falls), scoreboard and per-frame serial timing monitor.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                if (rst_seen[i]) begin
                    checks++;
                    if (nss[i] !== 1'b1 || sclk[i] !== 1'b1 || sd[i] !== 12'h0 ||
                        dr[i] !== 1'b0 || fe[i] !== 1'b0 || ovr[i] !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_outputs dut%0d cyc %0d: nss=%b sclk=%b sd=%h dr=%b fe=%b ovr=%b, required 1 1 000 0 0 0",
                                 i, cyc, nss[i], sclk[i], sd[i], dr[i], fe[i], ovr[i]);
                    end
                    in_frame[i] = 1'b0;
                    exp_sd[i]   = 12'h0;
                    exp_fe[i]   = 1'b0;
                end else begin
                    if (prev_nss[i] && !nss[i]) begin
                        adc_w[i] = 16'h0;
                        if (adcq.size() != 0 && adcq[0].dut == i) begin
                            adc_e    = adcq.pop_front();
                            adc_w[i] = adc_e.w;
                        end
                        adc_idx[i]   = 15;
                        in_frame[i]  = 1'b1;
                        last_edge[i] = cyc;
                        rises[i]     = 0;
                        low_cnt[i]   = 0;
                        falls[i]++;
                    end else if (!nss[i] && prev_sclk[i] && !sclk[i] && adc_idx[i] >= 0) begin
                        miso[i] = adc_w[i][adc_idx[i]];
                        adc_idx[i]--;
                    end
                    if (dr[i] === 1'b1) begin
                        checks++;
                        if (sbq.size() == 0 || sbq[0].dut != i) begin
                            errors++;
                            $display("FAIL unexpected_ready dut%0d cyc %0d: DataReady=1, required 0", i, cyc);
                        end else begin
                            mon_e = sbq.pop_front();
                            exp_sd[i] = mon_e.data;
                            exp_fe[i] = mon_e.fe;
                            if (cyc != mon_e.t || sd[i] !== mon_e.data || fe[i] !== mon_e.fe) begin
                                errors++;
                                $display("FAIL data_ready dut%0d: got cyc=%0d sd=%h fe=%b, required cyc=%0d sd=%h fe=%b",
                                         i, cyc, sd[i], fe[i], mon_e.t, mon_e.data, mon_e.fe);
                            end
                        end
                    end
                    checks++;
                    if (sd[i] !== exp_sd[i] || fe[i] !== exp_fe[i]) begin
                        errors++;
                        $display("FAIL data_hold dut%0d cyc %0d: sd=%h fe=%b, required sd=%h fe=%b",
                                 i, cyc, sd[i], fe[i], exp_sd[i], exp_fe[i]);
                    end
                    if (!nss[i] && in_frame[i]) begin
                        low_cnt[i]++;
                        if (sclk[i] !== prev_sclk[i]) begin
                            checks++;
                            if (cyc - last_edge[i] != CLK_DIV) begin
                                errors++;
                                $display("FAIL sclk_half_period dut%0d cyc %0d: %0d cycles, required %0d",
                                         i, cyc, cyc - last_edge[i], CLK_DIV);
                            end
                            last_edge[i] = cyc;
                            if (sclk[i]) rises[i]++;
                        end
                    end
                    if (!prev_nss[i] && nss[i] && in_frame[i]) begin
                        checks++;
                        if (rises[i] != FRAME_BITS || low_cnt[i] != LAT - 1) begin
                            errors++;
                            $display("FAIL frame_shape dut%0d cyc %0d: rises=%0d nss_low=%0d, required %0d and %0d",
                                     i, cyc, rises[i], low_cnt[i], FRAME_BITS, LAT - 1);
                        end
                        in_frame[i] = 1'b0;
                    end
                    if (nss[i]) begin
                        checks++;
                        if (sclk[i] !== 1'b1) begin
                            errors++;
                            $display("FAIL sclk_idle dut%0d cyc %0d: sclk=%b, required 1", i, cyc, sclk[i]);
                        end
                    end
                end
                prev_nss[i]  = nss[i];
                prev_sclk[i] = sclk[i];
            end
        end
    end

    task automatic do_reset(input int i, input int n);
        @(posedge clk);
        #1 rst[i] = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst[i] = 1'b0;
        rel = cyc;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_frame(input int i, input logic [15:0] w, input int t_ready);
        adc_t a;
        exp_t e;
        a.dut = i;  a.w = w;
        e.dut = i;  e.t = t_ready;  e.data = w[11:0];  e.fe = |w[15:12];
        adcq.push_back(a);
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input int limit);
        while (sbq.size() != 0 && cyc < limit) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout cyc %0d: %0d frames outstanding, required 0", cyc, sbq.size());
            sbq.delete();
            adcq.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nss[i] !== 1'b1 || sclk[i] !== 1'b1 || sd[i] !== 12'h0 ||
                dr[i] !== 1'b0 || fe[i] !== 1'b0 || ovr[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: nss=%b sclk=%b sd=%h dr=%b fe=%b ovr=%b, required 1 1 000 0 0 0",
                         i, nss[i], sclk[i], sd[i], dr[i], fe[i], ovr[i]);
            end
        end
    endtask

    // Default parameters: 0x0ABC, then an error frame 0x8FFF, then 0x0123.
    task automatic test_default_frames();
        logic [15:0] words [3] = '{16'h0ABC, 16'h8FFF, 16'h0123};
        int t0;
        en[0] = 1'b1;
        do_reset(0, 2);
        t0 = rel + DIV_A - 1;
        for (int k = 0; k < 3; k++) push_frame(0, words[k], t0 + LAT + k * DIV_A);
        wait_drain(t0 + LAT + 2 * DIV_A + 20);
        en[0] = 1'b0;
        checks++;
        if (ovr[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_default: got %b, required 0", ovr[0]);
        end
    endtask

    task automatic test_enable_drop();
        int t0;
        int f0;
        en[1] = 1'b1;
        do_reset(1, 2);
        t0 = rel + DIV_B - 1;
        push_frame(1, 16'h0456, t0 + LAT);
        wait_cyc(t0 + 100);
        en[1] = 1'b0;
        f0 = falls[1];
        wait_cyc(t0 + LAT + 3 * DIV_B);
        wait_drain(cyc + 1);
        checks++;
        if (falls[1] != f0 || nss[1] !== 1'b1) begin
            errors++;
            $display("FAIL enable_drop_quiet: nss falls=%0d nss=%b, required 0 and 1", falls[1] - f0, nss[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        en[1] = 1'b1;
        do_reset(1, 2);
        t0 = rel + DIV_B - 1;
        adcq.push_back('{dut: 1, w: 16'h0777});
        wait_cyc(t0 + 300);
        checks++;
        if (nss[1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_active_before_reset: nss=%b, required 0", nss[1]);
        end
        do_reset(1, 1);
        @(negedge clk);
        checks++;
        if (nss[1] !== 1'b1 || sclk[1] !== 1'b1 || sd[1] !== 12'h0 || dr[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: nss=%b sclk=%b sd=%h dr=%b, required 1 1 000 0",
                     nss[1], sclk[1], sd[1], dr[1]);
        end
        push_frame(1, 16'h0E5A, rel + DIV_B - 1 + LAT);
        wait_drain(rel + DIV_B - 1 + LAT + 20);
        en[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int t0;
        en[1] = 1'b1;
        do_reset(1, 2);
        t0 = rel + DIV_B - 1;
        for (int k = 0; k < 10; k++) begin
            w = {(k == 3) ? 4'h4 : 4'h0, 12'($urandom)};
            push_frame(1, w, t0 + LAT + k * DIV_B);
        end
        wait_drain(t0 + LAT + 9 * DIV_B + 20);
        en[1] = 1'b0;
        checks++;
        if (ovr[1] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_back_to_back: got %b, required 0", ovr[1]);
        end
    endtask

    // SAMPLE_DIV=500: the second tick lands mid-frame.
    task automatic test_overrun();
        en[2] = 1'b1;
        do_reset(2, 2);
        wait_cyc(rel + 2 * DIV_C - 5);
        checks++;
        if (ovr[2] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early: got %b, required 0", ovr[2]);
        end
        wait_cyc(rel + 2 * DIV_C + 5);
        checks++;
        if (ovr[2] !== 1'b1 || nss[2] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_set: ovr=%b nss=%b, required 1 0", ovr[2], nss[2]);
        end
        wait_cyc(rel + 6 * DIV_C);
        checks++;
        if (ovr[2] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b, required 1", ovr[2]);
        end
        en[2] = 1'b0;
        do_reset(2, 1);
        @(negedge clk);
        checks++;
        if (ovr[2] !== 1'b0 || nss[2] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b nss=%b, required 0 1", ovr[2], nss[2]);
        end
    endtask

    initial begin
        test_reset();
        test_default_frames();
        test_enable_drop();
        test_reset_mid_frame();
        test_back_to_back();
        test_overrun();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
